// File: rtl/nibble_serial_pkg.sv
// rtl/nibble_serial_pkg.sv - shared constants, FSM state type and sizing helper for nibble_serial_adder
package nibble_serial_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibble slices needed to cover a given operand width.
  function automatic int nibbles(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_slice.sv
// rtl/nibble_serial_adder_slice.sv - combinational 4-bit ripple-carry add slice
import nibble_serial_pkg::*;

module nibble_add_slice (
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic             ci,
  output logic [NIB_W-1:0] s4,
  output logic             co
);

  // Widen to NIB_W+1 so the carry falls out of the top bit.
  always_comb begin
    {co, s4} = {1'b0, a4} + {1'b0, b4} + {{NIB_W{1'b0}}, ci};
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit adder using one 4-bit slice, one nibble per clock (optional NIBBLE_SERIAL_OVF_EN adds ovf)
import nibble_serial_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBS = nibbles(WIDTH);
  localparam int CW   = ($clog2(NIBS) < 1) ? 1 : $clog2(NIBS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NIBS - 1);

  if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    idx_q, idx_d;
`ifdef NIBBLE_SERIAL_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0] s4;
  logic             c4;
  logic [WIDTH-1:0] sum_next;

  nibble_add_slice u_slice (
    .a4 (a_sh_q[NIB_W-1:0]),
    .b4 (b_sh_q[NIB_W-1:0]),
    .ci (carry_q),
    .s4 (s4),
    .co (c4)
  );

  // New nibble enters at the top so after NIBS steps the LSB nibble sits at bit 0.
  assign sum_next = {s4, sum_sh_q[WIDTH-1:NIB_W]};

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
`ifdef NIBBLE_SERIAL_OVF_EN
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
`ifdef NIBBLE_SERIAL_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d   = {{NIB_W{1'b0}}, a_sh_q[WIDTH-1:NIB_W]};
        b_sh_d   = {{NIB_W{1'b0}}, b_sh_q[WIDTH-1:NIB_W]};
        sum_sh_d = sum_next;
        carry_d  = c4;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d     = DONE;
          sum_d       = sum_next;
          cout_d      = c4;
          out_valid_d = 1'b1;
`ifdef NIBBLE_SERIAL_OVF_EN
          ovf_d       = (a_msb_q == b_msb_q) && (sum_next[WIDTH-1] != a_msb_q);
`endif
        end
      end
      DONE: begin
        // Result registers are left alone on handshake so sum/cout persist.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
`ifdef NIBBLE_SERIAL_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
`ifdef NIBBLE_SERIAL_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
